// File: rtl/stream_argmax_classifier_if.sv
// Valid/ready stream bundle for stream_argmax_classifier: score beats in, arg-max result out.
// out_margin exists only when ARGMAX_MARGIN_EN is defined.
interface stream_argmax_classifier_if #(
    parameter int WORD_SIZE  = 16,
    parameter int LAYER_SIZE = 10,
    parameter int LANES      = 1
);
    localparam int IDX_W = $clog2(LAYER_SIZE);

    logic                         in_valid;
    logic                         in_ready;
    logic [LANES*WORD_SIZE-1:0]   in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [IDX_W-1:0]             out_index;
    logic [WORD_SIZE-1:0]         out_value;
`ifdef ARGMAX_MARGIN_EN
    logic [WORD_SIZE-1:0]         out_margin;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_index, out_value, out_margin
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_index, out_value, out_margin
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_index, out_value
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_index, out_value
    );
`endif
endinterface

// File: rtl/stream_argmax_classifier.sv
// Streaming arg-max over one FC output layer delivered LANES scores per beat.
// Define ARGMAX_MARGIN_EN to also report the winner's margin over the runner-up.
module stream_argmax_classifier #(
    parameter int WORD_SIZE  = 16,
    parameter int LAYER_SIZE = 10,
    parameter int LANES      = 1
) (
    input logic                   clk,
    input logic                   reset,
    stream_argmax_classifier_if.slave bus
);
    localparam int IDX_W  = $clog2(LAYER_SIZE);
    localparam int BEATS  = LAYER_SIZE / LANES;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]                   state;
    logic [CNT_W-1:0]             beat_cnt;
    logic signed [WORD_SIZE-1:0]  run_max;
    logic [IDX_W-1:0]             run_idx;

    logic signed [WORD_SIZE-1:0]  lane_val;
    logic signed [WORD_SIZE-1:0]  beat_max;
    logic [LANE_W-1:0]            beat_lane;
    logic [IDX_W-1:0]             beat_elem;
    logic signed [WORD_SIZE-1:0]  next_max;
    logic [IDX_W-1:0]             next_idx;
    logic                         take_beat;
    logic                         last_beat;

`ifdef ARGMAX_MARGIN_EN
    localparam logic signed [WORD_SIZE-1:0] MOST_NEG = {1'b1, {(WORD_SIZE-1){1'b0}}};

    logic signed [WORD_SIZE-1:0]  run_second;
    logic signed [WORD_SIZE-1:0]  beat_second;
    logic signed [WORD_SIZE-1:0]  next_second;
    logic [WORD_SIZE:0]           margin_diff;
    logic [WORD_SIZE-1:0]         margin_sat;
`endif

    assign bus.in_ready = reset && (state == ACCUM);
    assign take_beat    = bus.in_valid && bus.in_ready;
    assign last_beat    = (beat_cnt == CNT_W'(BEATS - 1));
    assign beat_elem    = IDX_W'(int'(beat_cnt) * LANES + int'(beat_lane));

    // Strict > keeps the lowest lane among equal scores.
    always_comb begin
        lane_val  = '0;
        beat_max  = $signed(bus.in_data[WORD_SIZE-1:0]);
        beat_lane = '0;
`ifdef ARGMAX_MARGIN_EN
        beat_second = MOST_NEG;
`endif
        for (int l = 1; l < LANES; l++) begin
            lane_val = $signed(bus.in_data[l*WORD_SIZE +: WORD_SIZE]);
            if (lane_val > beat_max) begin
`ifdef ARGMAX_MARGIN_EN
                if (beat_max > beat_second) beat_second = beat_max;
`endif
                beat_max  = lane_val;
                beat_lane = LANE_W'(l);
            end
`ifdef ARGMAX_MARGIN_EN
            else if (lane_val > beat_second) begin
                beat_second = lane_val;
            end
`endif
        end
    end

    always_comb begin
        if (beat_cnt == '0 || beat_max > run_max) begin
            next_max = beat_max;
            next_idx = beat_elem;
        end else begin
            next_max = run_max;
            next_idx = run_idx;
        end
    end

`ifdef ARGMAX_MARGIN_EN
    // A displaced running max becomes a runner-up candidate; a losing beat winner competes with the old runner-up.
    always_comb begin
        if (beat_cnt == '0)
            next_second = beat_second;
        else if (beat_max > run_max)
            next_second = (run_max > beat_second) ? run_max : beat_second;
        else
            next_second = (beat_max > run_second) ? beat_max : run_second;

        margin_diff = {next_max[WORD_SIZE-1], next_max} - {next_second[WORD_SIZE-1], next_second};
        margin_sat  = margin_diff[WORD_SIZE] ? '1 : margin_diff[WORD_SIZE-1:0];
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ACCUM;
            beat_cnt      <= '0;
            run_max       <= '0;
            run_idx       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_index <= '0;
            bus.out_value <= '0;
`ifdef ARGMAX_MARGIN_EN
            run_second     <= '0;
            bus.out_margin <= '0;
`endif
        end else if (state == ACCUM) begin
            if (take_beat) begin
                run_max <= next_max;
                run_idx <= next_idx;
`ifdef ARGMAX_MARGIN_EN
                run_second <= next_second;
`endif
                if (last_beat) begin
                    bus.out_index <= next_idx;
                    bus.out_value <= next_max;
`ifdef ARGMAX_MARGIN_EN
                    bus.out_margin <= margin_sat;
`endif
                    bus.out_valid <= 1'b1;
                    beat_cnt      <= '0;
                    state         <= HOLD;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end else begin
            if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
                state         <= ACCUM;
            end
        end
    end
endmodule

// File: tb/tb_stream_argmax_classifier.sv
// Self-checking bench for stream_argmax_classifier: a LANES=1 and a LANES=5 instance checked against a reference model.
// Margin checks are compiled in when ARGMAX_MARGIN_EN is defined.
module tb_stream_argmax_classifier;
    localparam int W = 16;
    localparam int N = 10;

    typedef logic [N*W-1:0] frame_t;
    typedef struct {
        logic [3:0]  idx;
        logic [15:0] val;
        logic [15:0] mar;
    } result_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cycle = 0;
    result_t q1[$];
    result_t q5[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    stream_argmax_classifier_if #(.WORD_SIZE(W), .LAYER_SIZE(N), .LANES(1)) bus1 ();
    stream_argmax_classifier_if #(.WORD_SIZE(W), .LAYER_SIZE(N), .LANES(5)) bus5 ();

    stream_argmax_classifier #(.WORD_SIZE(W), .LAYER_SIZE(N), .LANES(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );
    stream_argmax_classifier #(.WORD_SIZE(W), .LAYER_SIZE(N), .LANES(5)) dut5 (
        .clk(clk), .reset(reset), .bus(bus5)
    );

    // Reference: first index of the maximum; runner-up is the largest score at any other index.
    function automatic result_t model(input frame_t f);
        result_t r;
        int best, best_v, second_v, v;
        best   = 0;
        best_v = int'($signed(f[15:0]));
        for (int i = 1; i < N; i++) begin
            v = int'($signed(f[i*W +: W]));
            if (v > best_v) begin
                best   = i;
                best_v = v;
            end
        end
        second_v = -100000;
        for (int i = 0; i < N; i++) begin
            v = int'($signed(f[i*W +: W]));
            if (i != best && v > second_v) second_v = v;
        end
        r.idx = 4'(best);
        r.val = 16'(best_v);
        r.mar = 16'(best_v - second_v);
        return r;
    endfunction

    function automatic frame_t from_ints(input int a[N]);
        frame_t f;
        for (int i = 0; i < N; i++) f[i*W +: W] = 16'(a[i]);
        return f;
    endfunction

    function automatic frame_t random_frame();
        frame_t f;
        logic   narrow;
        narrow = ($urandom_range(0, 1) == 1);
        for (int i = 0; i < N; i++)
            f[i*W +: W] = narrow ? 16'($urandom_range(0, 4) - 2) : 16'($urandom);
        return f;
    endfunction

    // Called at a negedge; returns at the negedge just after the beat transferred.
    task automatic send_beat1(input logic [15:0] d);
        int waits = 0;
        bus1.in_valid = 1'b1;
        bus1.in_data  = d;
        while (!bus1.in_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (!bus1.in_ready) begin
            tests++;
            fails++;
            $display("[TB] FAIL beat_accept_l1: in_ready=%b, required 1 within 200 cycles", bus1.in_ready);
        end
        @(negedge clk);
        bus1.in_valid = 1'b0;
    endtask

    task automatic send_beat5(input logic [5*W-1:0] d);
        int waits = 0;
        bus5.in_valid = 1'b1;
        bus5.in_data  = d;
        while (!bus5.in_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (!bus5.in_ready) begin
            tests++;
            fails++;
            $display("[TB] FAIL beat_accept_l5: in_ready=%b, required 1 within 200 cycles", bus5.in_ready);
        end
        @(negedge clk);
        bus5.in_valid = 1'b0;
    endtask

    task automatic send_frame1(input frame_t f, input int max_gap);
        q1.push_back(model(f));
        for (int i = 0; i < N; i++) begin
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
            send_beat1(f[i*W +: W]);
        end
    endtask

    task automatic send_frame5(input frame_t f, input int max_gap);
        q5.push_back(model(f));
        for (int b = 0; b < N/5; b++) begin
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
            send_beat5(f[b*5*W +: 5*W]);
        end
    endtask

    task automatic test_reset();
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b1;
        bus5.in_valid = 1'b0; bus5.in_data = '0; bus5.out_ready = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (bus1.out_valid !== 1'b0 || bus1.out_index !== '0 || bus1.out_value !== '0) begin
            fails++;
            $display("[TB] FAIL reset_out_l1: valid=%b idx=%0d val=%h, required 0/0/0000",
                     bus1.out_valid, bus1.out_index, bus1.out_value);
        end
        tests++;
        if (bus5.out_valid !== 1'b0 || bus5.out_index !== '0 || bus5.out_value !== '0) begin
            fails++;
            $display("[TB] FAIL reset_out_l5: valid=%b idx=%0d val=%h, required 0/0/0000",
                     bus5.out_valid, bus5.out_index, bus5.out_value);
        end
        tests++;
        if (bus1.in_ready !== 1'b0 || bus5.in_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_in_ready: l1=%b l5=%b, required 0/0", bus1.in_ready, bus5.in_ready);
        end
`ifdef ARGMAX_MARGIN_EN
        tests++;
        if (bus1.out_margin !== '0 || bus5.out_margin !== '0) begin
            fails++;
            $display("[TB] FAIL reset_margin: l1=%h l5=%h, required 0000", bus1.out_margin, bus5.out_margin);
        end
`endif
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (bus1.in_ready !== 1'b1 || bus5.in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL ready_after_reset: l1=%b l5=%b, required 1/1", bus1.in_ready, bus5.in_ready);
        end
    endtask

    task automatic test_tie();
        int t1[N] = '{3, -7, 12, 5, 0, 12, -1, 4, 9, 2};
        result_t exp;
        send_frame1(from_ints(t1), 0);
        tests++;
        if (bus1.out_valid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL tie_latency: out_valid=%b one cycle after last beat, required 1", bus1.out_valid);
        end
        exp = q1.pop_front();
        tests++;
        if (bus1.out_index !== exp.idx || bus1.out_value !== exp.val) begin
            fails++;
            $display("[TB] FAIL tie_result: got idx=%0d val=%h, required idx=%0d val=%h",
                     bus1.out_index, bus1.out_value, exp.idx, exp.val);
        end
`ifdef ARGMAX_MARGIN_EN
        tests++;
        if (bus1.out_margin !== exp.mar) begin
            fails++;
            $display("[TB] FAIL tie_margin: got %h, required %h", bus1.out_margin, exp.mar);
        end
`endif
        @(negedge clk);
        tests++;
        if (bus1.out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL tie_valid_drop: out_valid=%b after take, required 0", bus1.out_valid);
        end
    endtask

    task automatic test_extremes();
        int neg[N]  = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
        int high[N] = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, 32767};
        result_t exp;
        for (int k = 0; k < 2; k++) begin
            send_frame1(from_ints(k == 0 ? neg : high), 0);
            exp = q1.pop_front();
            tests++;
            if (bus1.out_valid !== 1'b1 || bus1.out_index !== exp.idx || bus1.out_value !== exp.val) begin
                fails++;
                $display("[TB] FAIL extreme_%0d: got valid=%b idx=%0d val=%h, required 1 idx=%0d val=%h",
                         k, bus1.out_valid, bus1.out_index, bus1.out_value, exp.idx, exp.val);
            end
`ifdef ARGMAX_MARGIN_EN
            tests++;
            if (bus1.out_margin !== exp.mar) begin
                fails++;
                $display("[TB] FAIL extreme_margin_%0d: got %h, required %h", k, bus1.out_margin, exp.mar);
            end
`endif
            @(negedge clk);
        end
    endtask

    task automatic test_lanes();
        int t3[N] = '{1, 9, 9, 2, 3, 9, 0, 0, 0, 0};
        result_t exp;
        send_frame5(from_ints(t3), 0);
        tests++;
        if (bus5.out_valid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL lanes_latency: out_valid=%b one cycle after 2nd beat, required 1", bus5.out_valid);
        end
        exp = q5.pop_front();
        tests++;
        if (bus5.out_index !== exp.idx || bus5.out_value !== exp.val) begin
            fails++;
            $display("[TB] FAIL lanes_result: got idx=%0d val=%h, required idx=%0d val=%h",
                     bus5.out_index, bus5.out_value, exp.idx, exp.val);
        end
`ifdef ARGMAX_MARGIN_EN
        tests++;
        if (bus5.out_margin !== exp.mar) begin
            fails++;
            $display("[TB] FAIL lanes_margin: got %h, required %h", bus5.out_margin, exp.mar);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int ta[N] = '{-5, 40, 7, 40, -100, 3, 39, 0, 1, 2};
        int tb[N] = '{6, 6, -2, 8, 8, 1, 0, 11, -11, 5};
        frame_t fb;
        result_t exp;
        fb = from_ints(tb);
        bus1.out_ready = 1'b0;
        send_frame1(from_ints(ta), 0);
        exp = q1[0];
        bus1.in_valid = 1'b1;
        bus1.in_data  = fb[W-1:0];
        for (int c = 0; c < 20; c++) begin
            tests++;
            if (bus1.in_ready !== 1'b0 || bus1.out_valid !== 1'b1 ||
                bus1.out_index !== exp.idx || bus1.out_value !== exp.val) begin
                fails++;
                $display("[TB] FAIL hold_cycle_%0d: ready=%b valid=%b idx=%0d val=%h, required 0 1 idx=%0d val=%h",
                         c, bus1.in_ready, bus1.out_valid, bus1.out_index, bus1.out_value, exp.idx, exp.val);
            end
            @(negedge clk);
        end
        bus1.out_ready = 1'b1;
        exp = q1.pop_front();
        tests++;
        if (bus1.out_valid !== 1'b1 || bus1.out_index !== exp.idx || bus1.out_value !== exp.val) begin
            fails++;
            $display("[TB] FAIL hold_release: got valid=%b idx=%0d val=%h, required 1 idx=%0d val=%h",
                     bus1.out_valid, bus1.out_index, bus1.out_value, exp.idx, exp.val);
        end
        send_frame1(fb, 0);
        exp = q1.pop_front();
        tests++;
        if (bus1.out_valid !== 1'b1 || bus1.out_index !== exp.idx || bus1.out_value !== exp.val) begin
            fails++;
            $display("[TB] FAIL after_hold_frame: got valid=%b idx=%0d val=%h, required 1 idx=%0d val=%h",
                     bus1.out_valid, bus1.out_index, bus1.out_value, exp.idx, exp.val);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bus1.out_ready = 1'b1;
        fork
            begin
                for (int f = 0; f < 5; f++) send_frame1(random_frame(), 0);
            end
            begin
                int prev = 0;
                int waits;
                result_t exp;
                for (int k = 0; k < 5; k++) begin
                    waits = 0;
                    while (!bus1.out_valid && waits < 100) begin
                        @(negedge clk);
                        waits++;
                    end
                    tests++;
                    if (!bus1.out_valid || q1.size() == 0) begin
                        fails++;
                        $display("[TB] FAIL b2b_timeout_%0d: out_valid=%b queued=%0d, required 1 and >0",
                                 k, bus1.out_valid, q1.size());
                    end else begin
                        exp = q1.pop_front();
                        if (bus1.out_index !== exp.idx || bus1.out_value !== exp.val) begin
                            fails++;
                            $display("[TB] FAIL b2b_result_%0d: got idx=%0d val=%h, required idx=%0d val=%h",
                                     k, bus1.out_index, bus1.out_value, exp.idx, exp.val);
                        end
                        if (k > 0) begin
                            tests++;
                            if (cycle - prev !== 11) begin
                                fails++;
                                $display("[TB] FAIL b2b_period_%0d: got %0d cycles, required 11", k, cycle - prev);
                            end
                        end
                        prev = cycle;
                    end
                    @(negedge clk);
                end
            end
        join
    endtask

    task automatic test_random();
        fork
            begin
                for (int f = 0; f < 1000; f++) send_frame1(random_frame(), 2);
            end
            begin
                for (int f = 0; f < 200; f++) send_frame5(random_frame(), 3);
            end
            begin
                int got = 0, guard = 0, bad = 0;
                result_t exp;
                while (got < 1000 && guard < 60000) begin
                    bus1.out_ready = ($urandom_range(0, 3) != 0);
                    if (bus1.out_valid && bus1.out_ready) begin
                        tests++;
                        exp = q1.pop_front();
                        if (bus1.out_index !== exp.idx || bus1.out_value !== exp.val
`ifdef ARGMAX_MARGIN_EN
                            || bus1.out_margin !== exp.mar
`endif
                        ) begin
                            fails++;
                            bad++;
                            if (bad < 10)
                                $display("[TB] FAIL random_l1_%0d: got idx=%0d val=%h, required idx=%0d val=%h",
                                         got, bus1.out_index, bus1.out_value, exp.idx, exp.val);
                        end
                        got++;
                    end
                    @(negedge clk);
                    guard++;
                end
                if (got < 1000) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL random_l1_timeout: got %0d results, required 1000", got);
                end
                bus1.out_ready = 1'b1;
            end
            begin
                int got = 0, guard = 0, bad = 0;
                result_t exp;
                while (got < 200 && guard < 60000) begin
                    bus5.out_ready = ($urandom_range(0, 2) != 0);
                    if (bus5.out_valid && bus5.out_ready) begin
                        tests++;
                        exp = q5.pop_front();
                        if (bus5.out_index !== exp.idx || bus5.out_value !== exp.val
`ifdef ARGMAX_MARGIN_EN
                            || bus5.out_margin !== exp.mar
`endif
                        ) begin
                            fails++;
                            bad++;
                            if (bad < 10)
                                $display("[TB] FAIL random_l5_%0d: got idx=%0d val=%h, required idx=%0d val=%h",
                                         got, bus5.out_index, bus5.out_value, exp.idx, exp.val);
                        end
                        got++;
                    end
                    @(negedge clk);
                    guard++;
                end
                if (got < 200) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL random_l5_timeout: got %0d results, required 200", got);
                end
                bus5.out_ready = 1'b1;
            end
        join
        @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        int tx[N] = '{100, 200, 300, 30000, 5, 6, 7, 8, 9, 10};
        int tc[N] = '{5, -3, 7, 1, 0, 2, 6, -8, 4, 3};
        result_t exp;
        bus1.out_ready = 1'b0;
        send_frame1(from_ints(tx), 0);
        q1.delete();
        reset = 1'b0;
        #1;
        tests++;
        if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b0 || bus1.out_index !== '0 || bus1.out_value !== '0) begin
            fails++;
            $display("[TB] FAIL reset_in_hold: valid=%b ready=%b idx=%0d val=%h, required 0 0 0 0000",
                     bus1.out_valid, bus1.in_ready, bus1.out_index, bus1.out_value);
        end
        @(negedge clk);
        reset = 1'b1;
        bus1.out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send_beat1(16'd30000);
        reset = 1'b0;
        #1;
        tests++;
        if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_midframe: valid=%b ready=%b, required 0 0", bus1.out_valid, bus1.in_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send_frame1(from_ints(tc), 0);
        exp = q1.pop_front();
        tests++;
        if (bus1.out_valid !== 1'b1 || bus1.out_index !== exp.idx || bus1.out_value !== exp.val) begin
            fails++;
            $display("[TB] FAIL post_reset_frame: got valid=%b idx=%0d val=%h, required 1 idx=%0d val=%h",
                     bus1.out_valid, bus1.out_index, bus1.out_value, exp.idx, exp.val);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_tie();
        test_extremes();
        test_lanes();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
